vector_add_arbiter: RTL and testbench
=====================================

// Module: vector_add_arbiter
// PURPOSE
//  Shares one vector_add datapath between NUM_REQ requesters via round-robin arbitration.
//  Each requester offers an (op1, op2) vector pair on a valid/ready handshake.
//  The sum, overflow flag and requester id go into a single-entry output register with a valid/ready handshake.
//  Sits between the geometry stages that issue vector sums and the shared vector_math adder.
// PARAMETERS
//  NUM_REQ   4   number of requesters, >= 2
//  OVF_CNT_W 16  width of the saturating overflow event counter
//  ID_W      localparam = $clog2(NUM_REQ)
// PORTS
//  clk          in   1                     clock, all state on rising edge
//  rst          in   1                     asynchronous, active-high reset
//  req_valid    in   NUM_REQ               per-requester operand pair valid
//  req_ready    out  NUM_REQ               per-requester accept; at most one bit high
//  req_op1      in   NUM_REQ x vector_t    first operand per requester
//  req_op2      in   NUM_REQ x vector_t    second operand per requester
//  res_valid    out  1                     output register holds a result
//  res_ready    in   1                     consumer accepts result
//  res_data     out  vector_t              op1 + op2 of granted requester
//  res_overflow out  1                     any-axis overflow for res_data
//  res_id       out  ID_W                  index of requester that produced res_data
//  ovf_count    out  OVF_CNT_W             saturating count of accepted overflowed results
// BEHAVIOUR
//  Reset (async assert, sync use on deassert):
//    res_valid=0, res_data=0, res_overflow=0, res_id=0, ovf_count=0, last_grant=NUM_REQ-1.
//  can_accept = !res_valid | res_ready.
//    Output slot is empty, or is being drained this cycle.
//  Arbitration (combinational): search req_valid starting at last_grant+1 mod NUM_REQ.
//    The first set bit is grant_idx. If no bit is set, there is no grant.
//  req_ready[i] = can_accept & grant & (i == grant_idx). All bits are 0 when !can_accept.
//  Transfer in: req_valid[i] & req_ready[i] on the same edge.
//    Load res_data/res_overflow from the vector_add output for requester i.
//    Set res_id=i, res_valid=1, last_grant=i.
//  Latency: one cycle. An operand accepted on edge N is visible on res_* after edge N.
//  Throughput: one result per cycle while res_ready=1.
//  Drain: res_valid & res_ready with no new transfer in -> res_valid=0.
//    res_data, res_overflow and res_id hold their last values.
//  Simultaneous drain and fill: the new result replaces the old in the same edge and res_valid stays 1.
//  Backpressure: while res_valid & !res_ready, all res_* outputs are held stable.
//    All req_ready bits are 0 and last_grant is unchanged.
//  Fairness: a continuously valid requester is granted within NUM_REQ transfers.
//    last_grant advances only on an actual transfer.
//  ovf_count increments on each transfer in whose sum overflowed.
//    It saturates at all-ones and does not wrap.
//  Overflow semantics and saturation/wrap of the sum itself are those of vector_add:
//    per-axis fixed_point_add; res_overflow is the OR of the x, y and z axis flags.
//  Reset mid-operation: any held result is discarded. No handshake completes on the reset edge.
//  Requesters must hold op1/op2 stable while valid and not ready. This block does not check that.
// STRUCTURE
//  One vector_add instance, fed by an NUM_REQ:1 operand mux on grant_idx.
//  Sub-module rr_arbiter (NUM_REQ):
//    Inputs: req vector, last_grant, enable.
//    Outputs: grant, grant_idx. Purely combinational.
//    Reused by later shared-datapath blocks.
//  Shared types and constants come from the vector and fixed_point packages (vector_t, VECTOR_ZERO).
//  Add to vector: typedef vector_req_t {vector_t op1; vector_t op2;}.
// TESTING
//  1. Reset, then req0 alone: op1=(1.0,2.0,3.0), op2=(0.5,0.5,0.5).
//     -> res_valid next cycle, res_data=(1.5,2.5,3.5), res_id=0, res_overflow=0.
//  2. All 4 requesters valid continuously, res_ready=1.
//     -> grants 0,1,2,3,0,... one per cycle, with res_id matching.
//  3. res_ready=0 for 5 cycles with a result held.
//     -> res_* stable, req_ready=0.
//     Then res_ready=1 with req2 valid -> drain and fill on the same edge, res_id=2.
//  4. op1.x = largest positive fixed_point, op2.x = 1 LSB.
//     -> res_overflow=1, ovf_count increments by 1. y/z overflow alone also sets res_overflow.
//  5. Force ovf_count to all-ones minus 1, then 3 overflowing transfers.
//     -> count saturates at all-ones.
//  6. Assert rst while res_valid=1 and requests pending.
//     -> all outputs return to reset values immediately; req0 wins first after release.

Source files
------------

// File: rtl/vector_add_arbiter_pkg.sv
// Shared fixed-point/vector types and the vector_add datapath function used by the arbiter.
// fixed_point_t is signed Q8.8; an add that overflows saturates to the rail and flags it.
package vector_add_arbiter_pkg;

    localparam int FP_W    = 16;
    localparam int FP_FRAC = 8;

    typedef logic signed [FP_W-1:0] fixed_point_t;

    localparam fixed_point_t FP_MAX = {1'b0, {(FP_W-1){1'b1}}};
    localparam fixed_point_t FP_MIN = {1'b1, {(FP_W-1){1'b0}}};

    typedef struct packed {
        fixed_point_t x;
        fixed_point_t y;
        fixed_point_t z;
    } vector_t;

    localparam vector_t VECTOR_ZERO = '0;

    typedef struct packed {
        vector_t op1;
        vector_t op2;
    } vector_req_t;

    typedef struct packed {
        fixed_point_t sum;
        logic         ovf;
    } fp_add_t;

    typedef struct packed {
        vector_t sum;
        logic    ovf;
    } vec_add_t;

    function automatic fp_add_t fixed_point_add(input fixed_point_t a, input fixed_point_t b);
        fixed_point_t s;
        fp_add_t      r;
        s     = a + b;
        // Same-sign operands producing a different-sign result is the only overflow case.
        r.ovf = (a[FP_W-1] == b[FP_W-1]) && (s[FP_W-1] != a[FP_W-1]);
        r.sum = r.ovf ? (a[FP_W-1] ? FP_MIN : FP_MAX) : s;
        return r;
    endfunction

    function automatic vec_add_t vector_add(input vector_t a, input vector_t b);
        fp_add_t  rx, ry, rz;
        vec_add_t r;
        rx    = fixed_point_add(a.x, b.x);
        ry    = fixed_point_add(a.y, b.y);
        rz    = fixed_point_add(a.z, b.z);
        r.sum = '{x: rx.sum, y: ry.sum, z: rz.sum};
        r.ovf = rx.ovf | ry.ovf | rz.ovf;
        return r;
    endfunction

endpackage

// File: rtl/vector_add_arbiter_if.sv
// Requester-side and result-side handshake bundle of the shared vector adder.
interface vector_add_arbiter_if #(parameter int NUM_REQ = 4);
    import vector_add_arbiter_pkg::*;

    localparam int ID_W = $clog2(NUM_REQ);

    logic [NUM_REQ-1:0] req_valid;
    logic [NUM_REQ-1:0] req_ready;
    vector_t [NUM_REQ-1:0] req_op1;
    vector_t [NUM_REQ-1:0] req_op2;
    logic            res_valid;
    logic            res_ready;
    vector_t         res_data;
    logic            res_overflow;
    logic [ID_W-1:0] res_id;

    modport master (
        output req_valid, req_op1, req_op2, res_ready,
        input  req_ready, res_valid, res_data, res_overflow, res_id
    );

    modport slave (
        input  req_valid, req_op1, req_op2, res_ready,
        output req_ready, res_valid, res_data, res_overflow, res_id
    );

endinterface

// File: rtl/vector_add_arbiter_rr_arbiter.sv
// Combinational round-robin picker: first set request at or after last_grant+1, wrapping.
module rr_arbiter #(
    parameter int N    = 4,
    parameter int ID_W = $clog2(N)
) (
    input  logic [N-1:0]    req_i,
    input  logic [ID_W-1:0] last_grant_i,
    input  logic            enable_i,
    output logic            grant_o,
    output logic [ID_W-1:0] grant_idx_o
);

    always_comb begin
        int idx;
        idx         = 0;
        grant_o     = 1'b0;
        grant_idx_o = '0;
        for (int off = 1; off <= N; off++) begin
            idx = (int'(last_grant_i) + off) % N;
            if (!grant_o && req_i[idx]) begin
                grant_o     = 1'b1;
                grant_idx_o = idx[ID_W-1:0];
            end
        end
        if (!enable_i) grant_o = 1'b0;
    end

endmodule

// File: rtl/vector_add_arbiter.sv
// Round-robin sharing of one vector_add between NUM_REQ requesters, into a single-entry
// valid/ready result register, plus a saturating count of overflowed results.
module vector_add_arbiter
    import vector_add_arbiter_pkg::*;
#(
    parameter int NUM_REQ   = 4,
    parameter int OVF_CNT_W = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    vector_add_arbiter_if.slave  bus,
    output logic [OVF_CNT_W-1:0] ovf_count
);

    localparam int ID_W = $clog2(NUM_REQ);

    logic                 res_valid_q, res_valid_d;
    vector_t              res_data_q, res_data_d;
    logic                 res_ovf_q, res_ovf_d;
    logic [ID_W-1:0]      res_id_q, res_id_d;
    logic [ID_W-1:0]      last_grant_q, last_grant_d;
    logic [OVF_CNT_W-1:0] ovf_cnt_q, ovf_cnt_d;

    logic            can_accept;
    logic            grant;
    logic [ID_W-1:0] grant_idx;
    vector_req_t     sel;
    vec_add_t        add;

    // Held low in reset so no requester sees a handshake that the registers will ignore.
    assign can_accept = (!res_valid_q || bus.res_ready) && !rst;

    rr_arbiter #(.N(NUM_REQ), .ID_W(ID_W)) u_rr (
        .req_i        (bus.req_valid),
        .last_grant_i (last_grant_q),
        .enable_i     (can_accept),
        .grant_o      (grant),
        .grant_idx_o  (grant_idx)
    );

    always_comb begin
        bus.req_ready = '0;
        if (grant) bus.req_ready[grant_idx] = 1'b1;
    end

    always_comb begin
        sel.op1 = bus.req_op1[grant_idx];
        sel.op2 = bus.req_op2[grant_idx];
        add     = vector_add(sel.op1, sel.op2);
    end

    always_comb begin
        res_valid_d  = res_valid_q;
        res_data_d   = res_data_q;
        res_ovf_d    = res_ovf_q;
        res_id_d     = res_id_q;
        last_grant_d = last_grant_q;
        ovf_cnt_d    = ovf_cnt_q;
        if (res_valid_q && bus.res_ready) res_valid_d = 1'b0;
        // grant already implies the selected requester is valid, so grant is the transfer.
        if (grant) begin
            res_valid_d  = 1'b1;
            res_data_d   = add.sum;
            res_ovf_d    = add.ovf;
            res_id_d     = grant_idx;
            last_grant_d = grant_idx;
            if (add.ovf && ovf_cnt_q != '1) ovf_cnt_d = ovf_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            res_valid_q  <= 1'b0;
            res_data_q   <= VECTOR_ZERO;
            res_ovf_q    <= 1'b0;
            res_id_q     <= '0;
            last_grant_q <= ID_W'(NUM_REQ - 1);
            ovf_cnt_q    <= '0;
        end else begin
            res_valid_q  <= res_valid_d;
            res_data_q   <= res_data_d;
            res_ovf_q    <= res_ovf_d;
            res_id_q     <= res_id_d;
            last_grant_q <= last_grant_d;
            ovf_cnt_q    <= ovf_cnt_d;
        end
    end

    assign bus.res_valid    = res_valid_q;
    assign bus.res_data     = res_data_q;
    assign bus.res_overflow = res_ovf_q;
    assign bus.res_id       = res_id_q;
    assign ovf_count        = ovf_cnt_q;

endmodule

// File: tb/tb_vector_add_arbiter.sv
// Directed bench for vector_add_arbiter; Q8.8 operands, narrow overflow counter to reach saturation.
module tb_vector_add_arbiter;
    import vector_add_arbiter_pkg::*;

    localparam int NREQ = 4;
    localparam int CW   = 3;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [CW-1:0] ovf_count;
    int            n_vec = 0;
    int            n_err = 0;

    vector_add_arbiter_if #(.NUM_REQ(NREQ)) bus ();

    vector_add_arbiter #(.NUM_REQ(NREQ), .OVF_CNT_W(CW)) dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus.slave),
        .ovf_count (ovf_count)
    );

    always #5 clk = ~clk;

    function automatic vector_t mk(input logic [15:0] x, input logic [15:0] y, input logic [15:0] z);
        vector_t v;
        v = {x, y, z};
        return v;
    endfunction

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input int idx, input vector_t a, input vector_t b);
        bus.req_valid      = '0;
        bus.req_valid[idx] = 1'b1;
        bus.req_op1[idx]   = a;
        bus.req_op2[idx]   = b;
        tick();
        bus.req_valid = '0;
    endtask

    task automatic chk_res(input string tag, input vector_t d, input logic ovf, input int id, input int cnt);
        chk({tag, ".valid"}, 64'(bus.res_valid), 64'd1);
        chk({tag, ".data"}, 64'(bus.res_data), 64'(d));
        chk({tag, ".ovf"}, 64'(bus.res_overflow), 64'(ovf));
        chk({tag, ".id"}, 64'(bus.res_id), 64'(id));
        chk({tag, ".cnt"}, 64'(ovf_count), 64'(cnt));
    endtask

    initial begin
        bus.req_valid = '1;
        bus.req_op1   = '0;
        bus.req_op2   = '0;
        bus.res_ready = 1'b1;
        repeat (3) tick();
        chk("rst.valid", 64'(bus.res_valid), 64'd0);
        chk("rst.data", 64'(bus.res_data), 64'd0);
        chk("rst.id", 64'(bus.res_id), 64'd0);
        chk("rst.cnt", 64'(ovf_count), 64'd0);
        chk("rst.ready", 64'(bus.req_ready), 64'd0);
        bus.req_valid = '0;
        rst = 1'b0;
        tick();

        // 1: single requester, one-cycle latency
        bus.req_valid = 4'b0001;
        bus.req_op1[0] = mk(16'h0100, 16'h0200, 16'h0300);
        bus.req_op2[0] = mk(16'h0080, 16'h0080, 16'h0080);
        #1 chk("t1.ready", 64'(bus.req_ready), 64'b0001);
        tick();
        bus.req_valid = '0;
        chk_res("t1", mk(16'h0180, 16'h0280, 16'h0380), 1'b0, 0, 0);

        // 2: all valid, rotation continues after last_grant=0
        for (int i = 0; i < NREQ; i++) begin
            bus.req_op1[i] = mk(16'(i * 256), 16'h0010, 16'h0000);
            bus.req_op2[i] = mk(16'h0001, 16'(i), 16'h0020);
        end
        bus.req_valid = '1;
        for (int k = 0; k < 8; k++) begin
            int e;
            e = (k + 1) % NREQ;
            #1 chk($sformatf("t2.ready%0d", k), 64'(bus.req_ready), 64'(1 << e));
            tick();
            chk_res($sformatf("t2.r%0d", k), mk(16'(e * 256 + 1), 16'(16 + e), 16'h0020), 1'b0, e, 0);
        end

        // 3: backpressure hold, then drain+fill, then drain
        bus.req_valid = 4'b0100;
        bus.res_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            tick();
            chk($sformatf("t3.ready%0d", k), 64'(bus.req_ready), 64'd0);
            chk_res($sformatf("t3.hold%0d", k), mk(16'h0001, 16'h0010, 16'h0020), 1'b0, 0, 0);
        end
        bus.res_ready = 1'b1;
        #1 chk("t3.fill_ready", 64'(bus.req_ready), 64'b0100);
        tick();
        bus.req_valid = '0;
        chk_res("t3.fill", mk(16'h0201, 16'h0012, 16'h0020), 1'b0, 2, 0);
        tick();
        chk("t3.drain_valid", 64'(bus.res_valid), 64'd0);
        chk("t3.drain_id", 64'(bus.res_id), 64'd2);

        // 4: per-axis overflow and non-overflow edges
        send(1, mk(16'h7FFF, 16'h0000, 16'h0000), mk(16'h0001, 16'h0000, 16'h0000));
        chk_res("t4.x", mk(16'h7FFF, 16'h0000, 16'h0000), 1'b1, 1, 1);
        send(3, mk(16'h0000, 16'h8000, 16'h0000), mk(16'h0000, 16'hFFFF, 16'h0000));
        chk_res("t4.y", mk(16'h0000, 16'h8000, 16'h0000), 1'b1, 3, 2);
        send(0, mk(16'h0000, 16'h0000, 16'h4000), mk(16'h0000, 16'h0000, 16'h4000));
        chk_res("t4.z", mk(16'h0000, 16'h0000, 16'h7FFF), 1'b1, 0, 3);
        send(2, mk(16'h7FFF, 16'h8000, 16'h0000), mk(16'h0000, 16'h7FFF, 16'h0000));
        chk_res("t4.none", mk(16'h7FFF, 16'hFFFF, 16'h0000), 1'b0, 2, 3);

        // 5: counter saturates at all-ones (7 for 3 bits)
        for (int k = 0; k < 6; k++) begin
            send(1, mk(16'h7FFF, 16'h0000, 16'h0000), mk(16'h0001, 16'h0000, 16'h0000));
            chk($sformatf("t5.cnt%0d", k), 64'(ovf_count), 64'((k < 4) ? 4 + k : 7));
        end

        // 6: async reset with a held result and pending requests
        bus.res_ready = 1'b0;
        bus.req_valid = '1;
        tick();
        chk("t6.pre_valid", 64'(bus.res_valid), 64'd1);
        #2 rst = 1'b1;
        #1;
        chk("t6.valid", 64'(bus.res_valid), 64'd0);
        chk("t6.data", 64'(bus.res_data), 64'd0);
        chk("t6.ovf", 64'(bus.res_overflow), 64'd0);
        chk("t6.id", 64'(bus.res_id), 64'd0);
        chk("t6.cnt", 64'(ovf_count), 64'd0);
        chk("t6.ready", 64'(bus.req_ready), 64'd0);
        tick();
        bus.res_ready = 1'b1;
        rst = 1'b0;
        #1 chk("t6.first_ready", 64'(bus.req_ready), 64'b0001);
        tick();
        chk("t6.first_id", 64'(bus.res_id), 64'd0);
        chk("t6.first_valid", 64'(bus.res_valid), 64'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
